// File: rtl/mem_dump_unit_if.sv
// rtl/mem_dump_unit_if.sv - memory read port and UART TX bus used by mem_dump_unit
//
// Purpose: groups the memory read port and the UART transmit handshake of the
// memory dump unit into one bundle.
// Ports (signals):
//   o_mem_r_addr       byte address to memory_32 i_r_addr
//   o_mem_r_en         read enable to memory_32 i_r_en
//   o_mem_r_addressing access size to memory_32 (always word)
//   i_mem_r_data       read data from memory_32 o_r_data (valid the cycle after o_mem_r_en)
//   o_tx_data          byte presented to the UART TX
//   o_tx_start         one-cycle transmit start pulse
//   i_tx_done          one-cycle pulse from the UART TX when a byte has been sent
// Modports: master = dump unit side, slave = memory/UART side.
interface mem_dump_unit_if #(
  parameter int NB_DATA_BUS = 32,
  parameter int NB_ADDRESS  = 6,
  parameter int NB_BYTE     = 8
);
  logic [NB_ADDRESS-1:0]  o_mem_r_addr;
  logic                   o_mem_r_en;
  logic [1:0]             o_mem_r_addressing;
  logic [NB_DATA_BUS-1:0] i_mem_r_data;
  logic [NB_BYTE-1:0]     o_tx_data;
  logic                   o_tx_start;
  logic                   i_tx_done;

  modport master (
    output o_mem_r_addr, o_mem_r_en, o_mem_r_addressing, o_tx_data, o_tx_start,
    input  i_mem_r_data, i_tx_done
  );

  modport slave (
    input  o_mem_r_addr, o_mem_r_en, o_mem_r_addressing, o_tx_data, o_tx_start,
    output i_mem_r_data, i_tx_done
  );
endinterface

// File: rtl/mem_dump_unit.sv
// rtl/mem_dump_unit.sv - streams the whole data memory out to the UART TX byte by byte
//
// Purpose: on an i_start pulse, reads every word of memory_32 in address order
// and sends each word to the UART transmitter MSB first, then pulses o_done.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN -- when defined, an XOR checksum
// of all data bytes is sent as one extra byte after the last data byte.
// Ports:
//   i_clk      clock, all logic on posedge
//   i_reset    synchronous active-high reset
//   i_start    one-cycle dump request, honoured only when idle
//   o_busy     high whenever a dump is in progress
//   o_done     one-cycle pulse when the dump is complete
//   bus        memory read port and UART TX handshake (mem_dump_unit_if.master)
module mem_dump_unit #(
  parameter int NB_DATA_BUS = 32,
  parameter int NB_ADDRESS  = 6,
  parameter int NB_BYTE     = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  mem_dump_unit_if.master  bus
);

  localparam int NB_WORD_CNT    = NB_ADDRESS - 2;
  localparam int BYTES_PER_WORD = NB_DATA_BUS / NB_BYTE;
  localparam int NB_BYTE_CNT    = $clog2(BYTES_PER_WORD);
  localparam logic [NB_WORD_CNT-1:0] LAST_WORD = '1;
  localparam logic [NB_BYTE_CNT-1:0] LAST_BYTE = NB_BYTE_CNT'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_SEND, S_WAIT_TX, S_FINISH
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [NB_WORD_CNT-1:0]  r_word_cnt;
  logic [NB_BYTE_CNT-1:0]  r_byte_cnt;
  logic [NB_DATA_BUS-1:0]  r_shift;
  logic [NB_BYTE-1:0]      r_tx_data;
  logic                    w_last_byte;
  logic                    w_last_word;
  logic                    w_tx_done;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]      r_csum;
  logic                    r_csum_phase;  // set while the checksum byte is in flight
`endif

  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  assign w_last_word = (r_word_cnt == LAST_WORD);
  assign w_tx_done   = (r_state == S_WAIT_TX) && bus.i_tx_done;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_next = S_READ;
      S_READ:    w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_SEND;
      S_SEND:    w_state_next = S_WAIT_TX;
      S_WAIT_TX: begin
        if (bus.i_tx_done) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          if (r_csum_phase)                    w_state_next = S_FINISH;
          else if (w_last_byte && w_last_word) w_state_next = S_SEND;
`else
          if (w_last_byte && w_last_word)      w_state_next = S_FINISH;
`endif
          else if (w_last_byte)                w_state_next = S_READ;
          else                                 w_state_next = S_SEND;
        end
      end
      S_FINISH:  w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_tx_data  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      r_csum       <= '0;
      r_csum_phase <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            r_csum       <= '0;
            r_csum_phase <= 1'b0;
`endif
          end
        end
        S_CAPTURE: begin
          // o_tx_data is loaded on entry to SEND so it holds steady until the next SEND.
          r_shift    <= bus.i_mem_r_data;
          r_byte_cnt <= '0;
          r_tx_data  <= bus.i_mem_r_data[NB_DATA_BUS-1 -: NB_BYTE];
`ifdef MEM_DUMP_CHECKSUM_EN
          r_csum     <= r_csum ^ bus.i_mem_r_data[NB_DATA_BUS-1 -: NB_BYTE];
`endif
        end
        S_WAIT_TX: begin
`ifdef MEM_DUMP_CHECKSUM_EN
          if (w_tx_done && !r_csum_phase) begin
`else
          if (w_tx_done) begin
`endif
            r_shift    <= r_shift << NB_BYTE;
            r_byte_cnt <= r_byte_cnt + NB_BYTE_CNT'(1);
            if (w_last_byte) begin
              if (!w_last_word) begin
                r_word_cnt <= r_word_cnt + NB_WORD_CNT'(1);
              end
`ifdef MEM_DUMP_CHECKSUM_EN
              else begin
                r_csum_phase <= 1'b1;
                r_tx_data    <= r_csum;
              end
`endif
            end else begin
              r_tx_data <= r_shift[NB_DATA_BUS-NB_BYTE-1 -: NB_BYTE];
`ifdef MEM_DUMP_CHECKSUM_EN
              r_csum    <= r_csum ^ r_shift[NB_DATA_BUS-NB_BYTE-1 -: NB_BYTE];
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_mem_r_addr       = {r_word_cnt, 2'b00};
  assign bus.o_mem_r_en         = (r_state == S_READ);
  assign bus.o_mem_r_addressing = 2'b00;
  assign bus.o_tx_data          = r_tx_data;
  assign bus.o_tx_start         = (r_state == S_SEND);
  assign o_busy                 = (r_state != S_IDLE);
  assign o_done                 = (r_state == S_FINISH);

endmodule

// File: tb/tb_mem_dump_unit.sv
// tb/tb_mem_dump_unit.sv - directed self-checking bench for mem_dump_unit
module tb_mem_dump_unit;

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int NBYTES = 65;
`else
  localparam int NBYTES = 64;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic [31:0] mem [16];
  logic [31:0] rdata = '0;
  logic uart_done = 1'b0;
  logic spur_done = 1'b0;
  int   ucnt = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   start_cyc;

  logic [7:0] q_bytes [$];
  int         q_starts [$];
  logic [5:0] q_addr [$];
  int         done_cnt = 0;
  int         done_cyc = 0;

  always #5 clk = ~clk;

  mem_dump_unit_if bus ();
  assign bus.i_mem_r_data = rdata;
  assign bus.i_tx_done    = uart_done | spur_done;

  mem_dump_unit dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .bus     (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.o_mem_r_en) rdata <= mem[bus.o_mem_r_addr[5:2]];
  end

  // UART model: i_tx_done 10 cycles after each o_tx_start
  always @(negedge clk) begin
    uart_done = 1'b0;
    if (rst) ucnt = 0;
    else begin
      if (ucnt > 0) begin
        ucnt = ucnt - 1;
        if (ucnt == 0) uart_done = 1'b1;
      end
      if (bus.o_tx_start) ucnt = 10;
    end
  end

  always @(negedge clk) begin
    if (bus.o_tx_start === 1'b1) begin
      q_bytes.push_back(bus.o_tx_data);
      q_starts.push_back(cyc);
    end
    if (bus.o_mem_r_en === 1'b1) q_addr.push_back(bus.o_mem_r_addr);
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    q_bytes.delete();
    q_starts.delete();
    q_addr.delete();
    done_cnt = 0;
  endtask

  task automatic fill_ramp(input logic [31:0] w0);
    for (int k = 0; k < 16; k++) mem[k] = 32'h01010101 * k;
    mem[0] = w0;
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    logic [7:0]  x;
    if (i >= 64) begin
      x = '0;
      for (int j = 0; j < 64; j++) begin
        w = mem[j / 4];
        x = x ^ w[31 - 8 * (j % 4) -: 8];
      end
      return x;
    end
    w = mem[i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic check_full_dump(input string tag);
    check({tag, "_count"}, q_bytes.size(), NBYTES);
    check({tag, "_nreads"}, q_addr.size(), 16);
    check({tag, "_ndone"}, done_cnt, 1);
    for (int k = 0; k < 16 && k < q_addr.size(); k++)
      check({tag, "_addr"}, {26'd0, q_addr[k]}, 4 * k);
    for (int i = 0; i < NBYTES && i < q_bytes.size(); i++)
      check({tag, "_byte"}, {24'd0, q_bytes[i]}, {24'd0, exp_byte(i)});
  endtask

  initial begin
    int n;
    // reset
    repeat (2) @(negedge clk);
    check("rst_addr", {26'd0, bus.o_mem_r_addr}, 0);
    check("rst_ren", {31'd0, bus.o_mem_r_en}, 0);
    check("rst_addressing", {30'd0, bus.o_mem_r_addressing}, 0);
    check("rst_txdata", {24'd0, bus.o_tx_data}, 0);
    check("rst_txstart", {31'd0, bus.o_tx_start}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst = 1'b0;
    @(negedge clk);

    // word 0 byte order and latency
    fill_ramp(32'h0123abcd);
    clear_mon();
    pulse_start();
    check("busy_in_dump", {31'd0, busy}, 1);
    wait_done(3000);
    check("w0_b0", {24'd0, q_bytes[0]}, 32'h01);
    check("w0_b1", {24'd0, q_bytes[1]}, 32'h23);
    check("w0_b2", {24'd0, q_bytes[2]}, 32'hab);
    check("w0_b3", {24'd0, q_bytes[3]}, 32'hcd);
    check("first_start_lat", q_starts[0] - start_cyc, 3);
    check("same_word_gap", q_starts[1] - q_starts[0], 11);
    check("new_word_gap", q_starts[4] - q_starts[3], 13);
    check("addr_first", {26'd0, q_addr[0]}, 0);
    check("addr_second", {26'd0, q_addr[1]}, 4);
    check("done_lat", done_cyc - q_starts[NBYTES-1], 11);

    // full ramp dump
    fill_ramp(32'h0);
    clear_mon();
    pulse_start();
    wait_done(3000);
    check_full_dump("ramp");

`ifdef MEM_DUMP_CHECKSUM_EN
    for (int k = 0; k < 16; k++) mem[k] = '0;
    mem[0] = 32'h0123abcd;
    clear_mon();
    pulse_start();
    wait_done(3000);
    check("csum_count", q_bytes.size(), 65);
    check("csum_byte", {24'd0, q_bytes[q_bytes.size()-1]}, 32'h44);
`endif

    // spurious inputs
    fill_ramp(32'h0123abcd);
    clear_mon();
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("idle_txdone_busy", {31'd0, busy}, 0);
    check("idle_txdone_nostart", q_bytes.size(), 0);
    pulse_start();
    n = 0;
    while (n < 6 && (cyc - start_cyc) < 500) begin
      @(negedge clk);
      if (bus.o_tx_start === 1'b1) n++;
    end
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3000);
    check_full_dump("spur");
    repeat (20) @(negedge clk);
    check("spur_no_restart", {31'd0, busy}, 0);
    check("spur_single_done", done_cnt, 1);

    // reset mid-dump (WAIT_TX of word 5)
    clear_mon();
    pulse_start();
    n = 0;
    while (n < 21 && (cyc - start_cyc) < 1000) begin
      @(negedge clk);
      if (bus.o_tx_start === 1'b1) n++;
    end
    repeat (2) @(negedge clk);
    check("mid_addr_word5", {26'd0, bus.o_mem_r_addr}, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_addr", {26'd0, bus.o_mem_r_addr}, 0);
    check("mrst_ren", {31'd0, bus.o_mem_r_en}, 0);
    check("mrst_txdata", {24'd0, bus.o_tx_data}, 0);
    check("mrst_txstart", {31'd0, bus.o_tx_start}, 0);
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_done", {31'd0, done}, 0);
    clear_mon();
    pulse_start();
    wait_done(3000);
    check("restart_addr0", {26'd0, q_addr[0]}, 0);
    check("restart_byte0", {24'd0, q_bytes[0]}, 32'h01);
    check("restart_count", q_bytes.size(), NBYTES);

    // reset and start in the same cycle: reset wins
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_beats_start", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
